// File: rtl/dev_bus_arbiter.sv
// Two-master round-robin arbiter that runs one device-bus access at a time
// through IDLE -> ACCESS -> DONE. It faults out-of-window or misaligned addresses.
module dev_bus_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wd,
  input  logic [31:0] m1_wd,
  input  logic        m0_we,
  input  logic        m1_we,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_done,
  output logic        m1_done,
  output logic [31:0] m0_rd,
  output logic [31:0] m1_rd,
  output logic        m0_err,
  output logic        m1_err,
  output logic [31:0] PrAddr,
  output logic [31:0] PrWD,
  output logic        PrWE,
  input  logic [31:0] PrRD,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        id_q, id_d;
  logic        we_q, we_d;
  logic        ok_q, ok_d;
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic [31:0] rd0_q, rd0_d, rd1_q, rd1_d;
  logic [31:0] praddr_q, praddr_d;
  logic [31:0] prwd_q, prwd_d;
  logic        prwe_q, prwe_d;
  logic        busy_q, busy_d;

  logic        sel;
  logic [31:0] sel_addr;
  logic [31:0] sel_wd;
  logic        sel_we;
  logic        sel_ok;
  logic [31:0] cap_rd;

  // The selection is precomputed so the address check feeds the registered PrWE
  // directly. This keeps every output registered while PrWE still rises in ACCESS.
  always_comb begin
    sel      = (m0_req && m1_req) ? ~last_q : m1_req;
    sel_addr = sel ? m1_addr : m0_addr;
    sel_wd   = sel ? m1_wd   : m0_wd;
    sel_we   = sel ? m1_we   : m0_we;
    sel_ok   = (sel_addr >= 32'h0000_7F00) && (sel_addr <= 32'h0000_7F43) &&
               (sel_addr[1:0] == 2'b00);
    cap_rd   = (ok_q && !we_q) ? PrRD : '0;
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    we_d     = we_q;
    ok_d     = ok_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    rd0_d    = '0;
    rd1_d    = '0;
    praddr_d = '0;
    prwd_d   = '0;
    prwe_d   = 1'b0;
    busy_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          id_d     = sel;
          last_d   = sel;
          we_d     = sel_we;
          ok_d     = sel_ok;
          praddr_d = sel_addr;
          prwd_d   = sel_wd;
          prwe_d   = sel_we && sel_ok;
          gnt0_d   = ~sel;
          gnt1_d   = sel;
          busy_d   = 1'b1;
          state_d  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        gnt0_d  = ~id_q;
        gnt1_d  = id_q;
        done0_d = ~id_q;
        done1_d = id_q;
        err0_d  = ~id_q && !ok_q;
        err1_d  = id_q && !ok_q;
        rd0_d   = id_q ? '0 : cap_rd;
        rd1_d   = id_q ? cap_rd : '0;
        busy_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      ok_q     <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rd0_q    <= '0;
      rd1_q    <= '0;
      praddr_q <= '0;
      prwd_q   <= '0;
      prwe_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      we_q     <= we_d;
      ok_q     <= ok_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
      praddr_q <= praddr_d;
      prwd_q   <= prwd_d;
      prwe_q   <= prwe_d;
      busy_q   <= busy_d;
    end
  end

  assign m0_gnt  = gnt0_q;
  assign m1_gnt  = gnt1_q;
  assign m0_done = done0_q;
  assign m1_done = done1_q;
  assign m0_err  = err0_q;
  assign m1_err  = err1_q;
  assign m0_rd   = rd0_q;
  assign m1_rd   = rd1_q;
  assign PrAddr  = praddr_q;
  assign PrWD    = prwd_q;
  assign PrWE    = prwe_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Directed bench for dev_bus_arbiter. Every expected value below is worked out
// by hand from the transaction timing.
module tb_dev_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wd = '0, m1_wd = '0;
  logic        m0_we = 1'b0, m1_we = 1'b0;
  logic        m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err;
  logic [31:0] m0_rd, m1_rd;
  logic [31:0] PrAddr, PrWD;
  logic        PrWE, busy;
  logic [31:0] PrRD = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int prev_done_cyc = 0;
  int m1_done_seen = 0;

  dev_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wd(m0_wd), .m1_wd(m1_wd),
    .m0_we(m0_we), .m1_we(m1_we),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_done(m0_done), .m1_done(m1_done),
    .m0_rd(m0_rd), .m1_rd(m1_rd),
    .m0_err(m0_err), .m1_err(m1_err),
    .PrAddr(PrAddr), .PrWD(PrWD), .PrWE(PrWE),
    .PrRD(PrRD), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset
    tick(); tick();
    reset = 1'b1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_prwe", {31'd0, PrWE}, 32'd0);
    chk("rst_praddr", PrAddr, 32'd0);
    chk("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    chk("rst_done", {30'd0, m1_done, m0_done}, 32'd0);
    chk("rst_rd", m0_rd | m1_rd, 32'd0);

    // m0 read of 0x7F04
    m0_req = 1'b1; m0_addr = 32'h7F04; m0_we = 1'b0; PrRD = 32'h1234_5678;
    tick();
    chk("rd_gnt0", {31'd0, m0_gnt}, 32'd1);
    chk("rd_gnt1", {31'd0, m1_gnt}, 32'd0);
    chk("rd_busy", {31'd0, busy}, 32'd1);
    chk("rd_praddr", PrAddr, 32'h7F04);
    chk("rd_prwe", {31'd0, PrWE}, 32'd0);
    chk("rd_early_done", {31'd0, m0_done}, 32'd0);
    m0_req = 1'b0;
    tick();
    chk("rd_done", {31'd0, m0_done}, 32'd1);
    chk("rd_data", m0_rd, 32'h1234_5678);
    chk("rd_err", {31'd0, m0_err}, 32'd0);
    chk("rd_gnt_hold", {31'd0, m0_gnt}, 32'd1);
    chk("rd_done_praddr", PrAddr, 32'd0);
    tick();
    chk("rd_idle_done", {31'd0, m0_done}, 32'd0);
    chk("rd_idle_gnt", {31'd0, m0_gnt}, 32'd0);
    chk("rd_idle_busy", {31'd0, busy}, 32'd0);
    chk("rd_idle_rd", m0_rd, 32'd0);

    // m1 write of 0xAB to 0x7F40
    m1_req = 1'b1; m1_addr = 32'h7F40; m1_wd = 32'hAB; m1_we = 1'b1; PrRD = 32'hFFFF_FFFF;
    tick();
    chk("wr_gnt1", {31'd0, m1_gnt}, 32'd1);
    chk("wr_prwe", {31'd0, PrWE}, 32'd1);
    chk("wr_praddr", PrAddr, 32'h7F40);
    chk("wr_prwd", PrWD, 32'hAB);
    m1_req = 1'b0;
    tick();
    chk("wr_prwe_off", {31'd0, PrWE}, 32'd0);
    chk("wr_done", {31'd0, m1_done}, 32'd1);
    chk("wr_rd", m1_rd, 32'd0);
    chk("wr_err", {31'd0, m1_err}, 32'd0);
    chk("wr_m0_done", {31'd0, m0_done}, 32'd0);
    tick();

    // both hold req after reset: m0, m1, m0, m1; done spaced 3 cycles
    reset = 1'b0; tick(); reset = 1'b1;
    m0_req = 1'b1; m0_addr = 32'h7F00; m0_we = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h7F08; m1_we = 1'b0;
    PrRD = 32'h0000_5A5A;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("rr_gnt0", {31'd0, m0_gnt}, (t % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_gnt1", {31'd0, m1_gnt}, (t % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr_praddr", PrAddr, (t % 2 == 0) ? 32'h7F00 : 32'h7F08);
      tick();
      chk("rr_done", {30'd0, m1_done, m0_done}, (t % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_rd", m0_rd | m1_rd, 32'h0000_5A5A);
      if (t > 0) chk("rr_spacing", cyc - prev_done_cyc, 32'd3);
      prev_done_cyc = cyc;
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    chk("rr_stop_busy", {31'd0, busy}, 32'd0);

    // m0 write out of window, then misaligned read
    m0_req = 1'b1; m0_addr = 32'h7F44; m0_wd = 32'h55; m0_we = 1'b1;
    tick();
    chk("oow_prwe", {31'd0, PrWE}, 32'd0);
    chk("oow_gnt", {31'd0, m0_gnt}, 32'd1);
    m0_req = 1'b0;
    tick();
    chk("oow_done", {31'd0, m0_done}, 32'd1);
    chk("oow_err", {31'd0, m0_err}, 32'd1);
    chk("oow_rd", m0_rd, 32'd0);
    tick();
    chk("oow_idle_err", {31'd0, m0_err}, 32'd0);
    m0_req = 1'b1; m0_addr = 32'h7F06; m0_we = 1'b0; PrRD = 32'hDEAD_BEEF;
    tick();
    chk("mis_prwe", {31'd0, PrWE}, 32'd0);
    m0_req = 1'b0;
    tick();
    chk("mis_done", {31'd0, m0_done}, 32'd1);
    chk("mis_err", {31'd0, m0_err}, 32'd1);
    chk("mis_rd", m0_rd, 32'd0);
    tick();

    // reset during ACCESS of an m1 write
    m1_req = 1'b1; m1_addr = 32'h7F10; m1_wd = 32'h77; m1_we = 1'b1;
    tick();
    chk("abort_prwe_pre", {31'd0, PrWE}, 32'd1);
    chk("abort_gnt_pre", {31'd0, m1_gnt}, 32'd1);
    reset = 1'b0; m1_req = 1'b0;
    tick();
    reset = 1'b1;
    chk("abort_prwe", {31'd0, PrWE}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_gnt", {31'd0, m1_gnt}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      if (m1_done) m1_done_seen++;
      tick();
    end
    chk("abort_no_done", m1_done_seen, 32'd0);
    // last was restored to 1 by reset, so m0 wins a tie
    m0_req = 1'b1; m0_addr = 32'h7F20; m0_we = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h7F24; m1_we = 1'b0;
    tick();
    chk("tie_gnt0", {31'd0, m0_gnt}, 32'd1);
    chk("tie_gnt1", {31'd0, m1_gnt}, 32'd0);
    m0_req = 1'b0; m1_req = 1'b0;
    tick(); tick();

    // m0 drops req during ACCESS
    m0_req = 1'b1; m0_addr = 32'h7F3C; m0_we = 1'b0; PrRD = 32'hCAFE_0001;
    tick();
    chk("drop_gnt", {31'd0, m0_gnt}, 32'd1);
    m0_req = 1'b0;
    tick();
    chk("drop_done", {31'd0, m0_done}, 32'd1);
    chk("drop_rd", m0_rd, 32'hCAFE_0001);
    tick();
    chk("drop_idle_done", {31'd0, m0_done}, 32'd0);
    chk("drop_idle_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("drop_stay_idle", {31'd0, busy}, 32'd0);
    chk("drop_no_gnt", {31'd0, m0_gnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
